// File: rtl/dcache_ctrl.sv
// Blocking, direct-mapped, write-through, no-write-allocate L1 data cache
// controller. One request is in flight at a time; load hits answer in the
// next cycle, misses fetch a full 8-word line from data memory, and stores
// always write through to memory with a single-cycle write pulse.
//
// Request handshake: a request transfers on a rising edge where req_valid
// and req_ready are both high; req_ready depends only on controller state
// and rst, never on req_valid, and req_* are only looked at on that edge.
module dcache_ctrl #(
   parameter int NUM_LINES = 8,
   parameter int MEM_LAT   = 2,
   parameter int TAG_W     = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_we,
   input  logic [31:0]      req_addr,
   input  logic [31:0]      req_wdata,
   input  logic [TAG_W-1:0] req_tag,
   output logic             resp_valid,
   output logic             resp_is_store,
   output logic [31:0]      resp_data,
   output logic [TAG_W-1:0] resp_tag,
   output logic [31:0]      LdAddr_DM,
   input  logic [255:0]     LdData_cache,
   output logic [31:0]      StrAddr_DM,
   output logic [31:0]      WriteData_DM,
   output logic             WE_DM,
   output logic [31:0]      hit_cnt,
   output logic [31:0]      miss_cnt
);

   localparam int IDX_W  = $clog2(NUM_LINES);
   localparam int CTAG_W = 32 - 5 - IDX_W;
   localparam int CNT_W  = $clog2(MEM_LAT + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      STORE = 2'd2
   } state_t;

   state_t state;

   // Per-line storage. Only the valid bits need a reset.
   logic [NUM_LINES-1:0] line_valid;
   logic [CTAG_W-1:0]    line_tag  [NUM_LINES];
   logic [31:0]          line_data [NUM_LINES][8];

   // Fill bookkeeping. The line index and cache tag of an outstanding fill
   // are recovered from LdAddr_DM, which is held stable for the whole fill.
   logic [CNT_W-1:0] lat_cnt;
   logic [2:0]       fill_off;
   logic [IDX_W-1:0] fill_idx;
   logic [CTAG_W-1:0] fill_ctag;
   logic [31:0]      fill_word;
   logic             fill_done;

   // Request decode
   logic [2:0]        req_off;
   logic [IDX_W-1:0]  req_idx;
   logic [CTAG_W-1:0] req_ctag;
   logic              accept;
   logic              lookup_hit;
   logic              unused_addr_bits;

   assign req_off   = req_addr[4:2];
   assign req_idx   = req_addr[5+IDX_W-1:5];
   assign req_ctag  = req_addr[31:5+IDX_W];
   assign unused_addr_bits = ^req_addr[1:0];

   assign req_ready  = (state == IDLE) && !rst;
   assign accept     = req_valid && req_ready;
   assign lookup_hit = line_valid[req_idx] && (line_tag[req_idx] == req_ctag);

   assign fill_idx  = LdAddr_DM[5+IDX_W-1:5];
   assign fill_ctag = LdAddr_DM[31:5+IDX_W];
   assign fill_word = LdData_cache[{fill_off, 5'b0} +: 32];
   assign fill_done = (state == FILL) && (lat_cnt == CNT_W'(1));

   // Controller FSM: sequencing, registered outputs, valid bits and counters
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         lat_cnt       <= '0;
         fill_off      <= '0;
         line_valid    <= '0;
         resp_valid    <= 1'b0;
         resp_is_store <= 1'b0;
         resp_data     <= '0;
         resp_tag      <= '0;
         LdAddr_DM     <= '0;
         StrAddr_DM    <= '0;
         WriteData_DM  <= '0;
         WE_DM         <= 1'b0;
         hit_cnt       <= '0;
         miss_cnt      <= '0;
      end else begin
         resp_valid    <= 1'b0;
         resp_is_store <= 1'b0;
         WE_DM         <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  resp_tag <= req_tag;
                  if (req_we) begin
                     // Write-through: the memory write and the ack go out together.
                     state         <= STORE;
                     WE_DM         <= 1'b1;
                     StrAddr_DM    <= {req_addr[31:2], 2'b00};
                     WriteData_DM  <= req_wdata;
                     resp_valid    <= 1'b1;
                     resp_is_store <= 1'b1;
                     resp_data     <= '0;
                  end else if (lookup_hit) begin
                     resp_valid <= 1'b1;
                     resp_data  <= line_data[req_idx][req_off];
                     hit_cnt    <= hit_cnt + 32'd1;
                  end else begin
                     state     <= FILL;
                     LdAddr_DM <= {req_addr[31:5], 5'b0};
                     lat_cnt   <= CNT_W'(MEM_LAT);
                     fill_off  <= req_off;
                     miss_cnt  <= miss_cnt + 32'd1;
                  end
               end
            end
            FILL: begin
               lat_cnt <= lat_cnt - CNT_W'(1);
               if (fill_done) begin
                  line_valid[fill_idx] <= 1'b1;
                  resp_valid           <= 1'b1;
                  resp_data            <= fill_word;
                  state                <= IDLE;
               end
            end
            STORE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Line tag/data arrays: store-hit word update and full-line fill
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (accept && req_we && lookup_hit) begin
            line_data[req_idx][req_off] <= req_wdata;
         end else if (fill_done) begin
            line_tag[fill_idx] <= fill_ctag;
            for (int w = 0; w < 8; w++) begin
               line_data[fill_idx][w] <= LdData_cache[32*w +: 32];
            end
         end
      end
   end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Testbench for dcache_ctrl: directed sequence with literal expectations,
// then randomized traffic checked every cycle against a transaction-level
// model (resident line per index, flat memory image, response timeline).
module tb_dcache_ctrl;

   localparam int NUM_LINES = 8;
   localparam int MEM_LAT   = 2;
   localparam int TAG_W     = 6;

   // ---------------- clock / reset / DUT ----------------
   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             req_valid = 1'b0;
   logic             req_ready;
   logic             req_we = 1'b0;
   logic [31:0]      req_addr = '0;
   logic [31:0]      req_wdata = '0;
   logic [TAG_W-1:0] req_tag = '0;
   logic             resp_valid;
   logic             resp_is_store;
   logic [31:0]      resp_data;
   logic [TAG_W-1:0] resp_tag;
   logic [31:0]      LdAddr_DM;
   logic [255:0]     LdData_cache = '0;
   logic [31:0]      StrAddr_DM;
   logic [31:0]      WriteData_DM;
   logic             WE_DM;
   logic [31:0]      hit_cnt;
   logic [31:0]      miss_cnt;

   always #5 clk = ~clk;

   dcache_ctrl #(.NUM_LINES(NUM_LINES), .MEM_LAT(MEM_LAT), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
      .resp_valid(resp_valid), .resp_is_store(resp_is_store),
      .resp_data(resp_data), .resp_tag(resp_tag),
      .LdAddr_DM(LdAddr_DM), .LdData_cache(LdData_cache),
      .StrAddr_DM(StrAddr_DM), .WriteData_DM(WriteData_DM), .WE_DM(WE_DM),
      .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
   );

   // ---------------- data memory seen by the DUT ----------------
   logic [31:0] phys_mem [1024];

   always @(negedge clk) begin
      if (WE_DM === 1'b1) phys_mem[StrAddr_DM[11:2]] = WriteData_DM;
      for (int w = 0; w < 8; w++) begin
         logic [2:0] wi;
         wi = 3'(w);
         LdData_cache[32*w +: 32] = phys_mem[{LdAddr_DM[11:5], wi}];
      end
   end

   // ---------------- reference model / scoreboard ----------------
   typedef struct {
      int unsigned      cyc;
      bit               st;
      logic [31:0]      data;
      logic [TAG_W-1:0] tag;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] ref_mem [1024];
   bit          res_v    [NUM_LINES];
   logic [31:0] res_base [NUM_LINES];
   int unsigned cur = 0;
   int unsigned ready_from = 0;
   logic [31:0] exp_hit = '0, exp_miss = '0;
   logic [31:0] last_ld = '0, last_saddr = '0, last_wdata = '0;
   int          n_chk = 0, n_pass = 0;
   bit          chk_on = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_chk++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, expv, cur);
   endtask

   // Applies the effect of the rising edge that ends cycle 'cur'.
   task automatic model_edge();
      logic [31:0] base;
      int          idx;
      int          widx;
      if (rst) begin
         exp_q.delete();
         for (int i = 0; i < NUM_LINES; i++) res_v[i] = 0;
         exp_hit = '0; exp_miss = '0;
         last_ld = '0; last_saddr = '0; last_wdata = '0;
         ready_from = cur + 1;
      end else if (req_valid && cur >= ready_from) begin
         base = req_addr & 32'hFFFF_FFE0;
         idx  = int'((req_addr >> 5) % NUM_LINES);
         widx = int'((req_addr >> 2) & 32'h3FF);
         if (req_we) begin
            exp_q.push_back('{cyc: cur + 1, st: 1'b1, data: 32'h0, tag: req_tag});
            ref_mem[widx] = req_wdata;
            last_saddr = req_addr & 32'hFFFF_FFFC;
            last_wdata = req_wdata;
            ready_from = cur + 2;
         end else if (res_v[idx] && res_base[idx] == base) begin
            exp_q.push_back('{cyc: cur + 1, st: 1'b0, data: ref_mem[widx], tag: req_tag});
            exp_hit++;
            ready_from = cur + 1;
         end else begin
            exp_q.push_back('{cyc: cur + MEM_LAT + 1, st: 1'b0, data: ref_mem[widx], tag: req_tag});
            exp_miss++;
            res_v[idx] = 1;
            res_base[idx] = base;
            last_ld = base;
            ready_from = cur + MEM_LAT + 1;
         end
      end
      cur++;
   endtask

   // Every-cycle comparison of all DUT outputs against the model
   always @(negedge clk) begin
      if (chk_on) begin
         bit   have;
         exp_t e;
         have = (exp_q.size() > 0) && (exp_q[0].cyc == cur);
         e = '{cyc: 0, st: 1'b0, data: 32'h0, tag: '0};
         if (have) e = exp_q.pop_front();
         chk("resp_valid", 32'(resp_valid), 32'(have));
         chk("we_dm", 32'(WE_DM), 32'(have && e.st));
         if (have) begin
            chk("resp_is_store", 32'(resp_is_store), 32'(e.st));
            chk("resp_data", resp_data, e.data);
            chk("resp_tag", 32'(resp_tag), 32'(e.tag));
         end
         chk("req_ready", 32'(req_ready), 32'(!rst && cur >= ready_from));
         chk("hit_cnt", hit_cnt, exp_hit);
         chk("miss_cnt", miss_cnt, exp_miss);
         chk("ld_addr", LdAddr_DM, last_ld);
         chk("str_addr", StrAddr_DM, last_saddr);
         chk("write_data", WriteData_DM, last_wdata);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step(input bit v, input bit we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [TAG_W-1:0] t);
      req_valid = v; req_we = we; req_addr = a; req_wdata = wd; req_tag = t;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 32'h0, '0);
   endtask

   task automatic load(input logic [31:0] a, input logic [TAG_W-1:0] t);
      step(1'b1, 1'b0, a, 32'($urandom), t);
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [TAG_W-1:0] t);
      step(1'b1, 1'b1, a, d, t);
   endtask

   task automatic pin(input string name, input logic [31:0] act, input logic [31:0] expv);
      chk(name, act, expv);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      for (int k = 0; k < 1024; k++) begin
         phys_mem[k] = 32'hA000_0000 + 32'(k);
         ref_mem[k]  = 32'hA000_0000 + 32'(k);
      end

      rst = 1'b1;
      idle(1);
      chk_on = 1;
      idle(1);
      rst = 1'b0;
      @(negedge clk);
      pin("pin_reset_ready", 32'(req_ready), 32'd1);
      pin("pin_reset_miss", miss_cnt, 32'd0);

      // Cold miss on 0x40
      load(32'h40, 6'd3);
      @(negedge clk); pin("pin_fill_addr1", LdAddr_DM, 32'h40);
      idle(1);
      @(negedge clk); pin("pin_fill_addr2", LdAddr_DM, 32'h40);
      pin("pin_fill_quiet", 32'(resp_valid), 32'd0);
      idle(1);
      @(negedge clk);
      pin("pin_miss_data", resp_data, 32'hA000_0010);
      pin("pin_miss_tag", 32'(resp_tag), 32'd3);
      pin("pin_miss_cnt1", miss_cnt, 32'd1);

      // Back-to-back hits in the same line
      load(32'h44, 6'd4);
      @(negedge clk); pin("pin_hit_data1", resp_data, 32'hA000_0011);
      pin("pin_hit_ready", 32'(req_ready), 32'd1);
      load(32'h5C, 6'd5);
      @(negedge clk); pin("pin_hit_data2", resp_data, 32'hA000_0017);
      pin("pin_hit_cnt2", hit_cnt, 32'd2);

      // Store hit, then load the updated word
      store(32'h48, 32'hDEAD_BEEF, 6'd6);
      @(negedge clk);
      pin("pin_st_we", 32'(WE_DM), 32'd1);
      pin("pin_st_addr", StrAddr_DM, 32'h48);
      pin("pin_st_ack", 32'(resp_is_store), 32'd1);
      idle(1);
      @(negedge clk); pin("pin_st_we_off", 32'(WE_DM), 32'd0);
      load(32'h48, 6'd7);
      @(negedge clk); pin("pin_st_hit", resp_data, 32'hDEAD_BEEF);

      // Conflict misses on index 2
      load(32'h140, 6'd8);
      idle(2);
      @(negedge clk); pin("pin_conflict_data", resp_data, 32'hA000_0050);
      load(32'h40, 6'd9);
      idle(2);
      @(negedge clk);
      pin("pin_refill_data", resp_data, 32'hA000_0010);
      pin("pin_miss_cnt3", miss_cnt, 32'd3);

      // Store miss: no allocation, memory updated
      store(32'h200, 32'h1234_5678, 6'd10);
      idle(1);
      load(32'h200, 6'd11);
      idle(2);
      @(negedge clk);
      pin("pin_stmiss_data", resp_data, 32'h1234_5678);
      pin("pin_miss_cnt4", miss_cnt, 32'd4);

      // Reset during the first fill cycle of a 0x40 miss
      load(32'h140, 6'd12);
      idle(MEM_LAT);
      load(32'h40, 6'd13);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      @(negedge clk);
      pin("pin_abort_resp", 32'(resp_valid), 32'd0);
      pin("pin_abort_we", 32'(WE_DM), 32'd0);
      pin("pin_abort_miss", miss_cnt, 32'd0);
      pin("pin_abort_hit", hit_cnt, 32'd0);
      idle(MEM_LAT);
      load(32'h44, 6'd14);
      @(negedge clk); pin("pin_after_rst_miss", miss_cnt, 32'd1);
      idle(MEM_LAT);
      @(negedge clk);
      pin("pin_after_rst_data", resp_data, 32'hA000_0011);
      pin("pin_after_rst_tag", 32'(resp_tag), 32'd14);

      // Randomized traffic; req_valid is also raised while busy
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            rst = 1'b1;
            idle(1);
            rst = 1'b0;
         end else begin
            logic [31:0] a;
            bit          v, we;
            v  = ($urandom_range(0, 9) < 7);
            we = ($urandom_range(0, 9) < 3);
            a  = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 5)
               | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            step(v, we, a, $urandom, TAG_W'($urandom));
         end
      end
      idle(MEM_LAT + 3);
      chk("drain_empty", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
